// File: rtl/player_move_ctrl_pkg.sv
// Shared definitions for the player mover: FSM states, key direction codes
// and the wall tile id range shared with the map resources.
package player_move_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_CHECK = 2'd2,
      ST_COOL  = 2'd3
   } state_t;

   // The keyboard front end encodes key_dir with these same values.
   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   // Resource tile ids: the wall tiles occupy a contiguous inclusive range.
   localparam logic [15:0] RS_wall_0 = 16'h0010;
   localparam logic [15:0] RS_wall_1 = 16'h0011;
   localparam logic [15:0] RS_wall_2 = 16'h0012;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
   } cell_t;

endpackage

// File: rtl/player_move_ctrl_tile_pass_check.sv
// Combinational tile classifier: flags tile ids that block movement.
// Shared by anything that walks the map (player, enemies, NPCs).
module tile_pass_check
   import player_move_ctrl_pkg::*;
(
   input  logic [15:0] tile_id,
   output logic        blocking
);

   assign blocking = (tile_id >= RS_wall_0) && (tile_id <= RS_wall_2);

endmodule

// File: rtl/player_move_ctrl.sv
// Player step sequencer: accepts a direction, bounds-checks, reads the target
// tile, then commits or rejects the move, followed by an optional cooldown.
module player_move_ctrl
   import player_move_ctrl_pkg::*;
#(
   parameter int GRID_W   = 16,
   parameter int GRID_H   = 16,
   parameter int INIT_X   = 0,
   parameter int INIT_Y   = 0,
   parameter int COOLDOWN = 5_000_000,
   parameter int CD_W     = 23
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [1:0]  key_dir,
   output logic        key_ready,
   input  logic        pos_load,
   input  logic [3:0]  pos_load_x,
   input  logic [3:0]  pos_load_y,
   output logic        map_rd_en,
   output logic [3:0]  map_rd_x,
   output logic [3:0]  map_rd_y,
   input  logic [15:0] map_rd_data,
   output logic [3:0]  player_x,
   output logic [3:0]  player_y,
   output logic        move_done,
   output logic        bumped
);

   localparam logic [4:0]      X_LAST  = 5'(GRID_W - 1);
   localparam logic [4:0]      Y_LAST  = 5'(GRID_H - 1);
   localparam logic [CD_W-1:0] CD_LOAD = (COOLDOWN == 0) ? '0 : CD_W'(COOLDOWN - 1);
   localparam cell_t           INIT_POS = '{x: 4'(INIT_X), y: 4'(INIT_Y)};
   localparam state_t          AFTER_STEP = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;

   state_t          state_q, state_d;
   cell_t           pos_q, pos_d, tgt_q, tgt_d, rd_q, rd_d, step_tgt;
   logic            rd_en_q, rd_en_d, done_q, done_d, bump_q, bump_d;
   logic            ready_q, ready_d, off_grid, blocking;
   logic [CD_W-1:0] cnt_q, cnt_d;

   tile_pass_check u_pass (
      .tile_id  (map_rd_data),
      .blocking (blocking)
   );

   // Compares are widened so positions loaded past the grid edge still read as off-grid.
   always_comb begin
      off_grid = 1'b0;
      step_tgt = pos_q;
      case (dir_t'(key_dir))
         DIR_UP:    begin off_grid = (pos_q.y == 4'd0);          step_tgt.y = pos_q.y - 4'd1; end
         DIR_DOWN:  begin off_grid = ({1'b0, pos_q.y} >= Y_LAST); step_tgt.y = pos_q.y + 4'd1; end
         DIR_LEFT:  begin off_grid = (pos_q.x == 4'd0);          step_tgt.x = pos_q.x - 4'd1; end
         DIR_RIGHT: begin off_grid = ({1'b0, pos_q.x} >= X_LAST); step_tgt.x = pos_q.x + 4'd1; end
         default:   ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      tgt_d   = tgt_q;
      rd_d    = rd_q;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
      bump_d  = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (key_valid && ready_q) begin
               if (off_grid) begin
                  done_d  = 1'b1;
                  bump_d  = 1'b1;
                  cnt_d   = CD_LOAD;
                  state_d = AFTER_STEP;
               end else begin
                  tgt_d   = step_tgt;
                  rd_d    = step_tgt;
                  rd_en_d = 1'b1;
                  state_d = ST_READ;
               end
            end
         end
         ST_READ:  state_d = ST_CHECK;
         ST_CHECK: begin
            done_d  = 1'b1;
            bump_d  = blocking;
            if (!blocking) pos_d = tgt_q;
            cnt_d   = CD_LOAD;
            state_d = AFTER_STEP;
         end
         ST_COOL: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // A forced load aborts any step in flight and drops a same-cycle key.
      if (pos_load) begin
         pos_d   = '{x: pos_load_x, y: pos_load_y};
         state_d = ST_IDLE;
         cnt_d   = '0;
         rd_en_d = 1'b0;
         done_d  = 1'b0;
         bump_d  = 1'b0;
      end
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pos_q   <= INIT_POS;
         tgt_q   <= '0;
         rd_q    <= '0;
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         bump_q  <= 1'b0;
         ready_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         tgt_q   <= tgt_d;
         rd_q    <= rd_d;
         rd_en_q <= rd_en_d;
         done_q  <= done_d;
         bump_q  <= bump_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
      end
   end

   assign key_ready = ready_q;
   assign map_rd_en = rd_en_q;
   assign map_rd_x  = rd_q.x;
   assign map_rd_y  = rd_q.y;
   assign player_x  = pos_q.x;
   assign player_y  = pos_q.y;
   assign move_done = done_q;
   assign bumped    = bump_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: directed scenarios plus a random
// walk over a random map, checked against a grid-level step model.
module tb_player_move_ctrl;
   import player_move_ctrl_pkg::*;

   localparam int GW = 16;
   localparam int GH = 16;
   localparam int IX = 3;
   localparam int IY = 3;
   localparam int CD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [1:0]  key_dir = 2'd0;
   logic        key_ready;
   logic        pos_load = 1'b0;
   logic [3:0]  pos_load_x = 4'd0;
   logic [3:0]  pos_load_y = 4'd0;
   logic        map_rd_en;
   logic [3:0]  map_rd_x, map_rd_y;
   logic [15:0] map_rd_data = 16'h0;
   logic [3:0]  player_x, player_y;
   logic        move_done, bumped;

   int errors = 0;
   int checks = 0;
   int exp_x = IX;
   int exp_y = IY;
   logic [15:0] map_mem [16][16];

   player_move_ctrl #(
      .GRID_W(GW), .GRID_H(GH), .INIT_X(IX), .INIT_Y(IY), .COOLDOWN(CD), .CD_W(3)
   ) dut (
      .clk(clk), .rst(rst),
      .key_valid(key_valid), .key_dir(key_dir), .key_ready(key_ready),
      .pos_load(pos_load), .pos_load_x(pos_load_x), .pos_load_y(pos_load_y),
      .map_rd_en(map_rd_en), .map_rd_x(map_rd_x), .map_rd_y(map_rd_y),
      .map_rd_data(map_rd_data),
      .player_x(player_x), .player_y(player_y),
      .move_done(move_done), .bumped(bumped)
   );

   always #5 clk = ~clk;

   // Map RAM: data valid one cycle after the strobe, a wall id otherwise.
   always @(posedge clk)
      map_rd_data <= map_rd_en ? map_mem[map_rd_y][map_rd_x] : RS_wall_1;

   function automatic logic [15:0] rand_floor();
      logic [15:0] v;
      case ($urandom_range(0, 3))
         0: v = 16'h0000;
         1: v = 16'h000F;
         2: v = 16'h0013;
         default: begin
            v = 16'($urandom);
            if (v >= RS_wall_0 && v <= RS_wall_2) v = 16'h1234;
         end
      endcase
      return v;
   endfunction

   // One command from IDLE, checked cycle by cycle against the grid rules.
   task automatic do_step(input logic [1:0] d);
      int tx, ty, lat;
      bit off, wall;
      tx = exp_x; ty = exp_y;
      case (d)
         2'd0: ty = ty - 1;
         2'd1: ty = ty + 1;
         2'd2: tx = tx - 1;
         default: tx = tx + 1;
      endcase
      off  = (tx < 0) || (tx >= GW) || (ty < 0) || (ty >= GH);
      wall = 1'b0;
      if (!off) wall = (map_mem[ty][tx] >= RS_wall_0) && (map_mem[ty][tx] <= RS_wall_2);
      checks++;
      if (key_ready !== 1'b1) begin errors++; $display("FAIL step_ready_pre got=%b want=1", key_ready); end
      key_valid = 1'b1; key_dir = d;
      @(negedge clk);
      key_valid = 1'b0;
      if (off) begin
         lat = 1;
         checks++;
         if ({move_done, bumped, map_rd_en, key_ready, player_x, player_y} !== {4'b1100, 4'(exp_x), 4'(exp_y)}) begin
            errors++;
            $display("FAIL step_offgrid got done=%b bump=%b rd=%b rdy=%b pos=(%0d,%0d) want 1 1 0 0 (%0d,%0d)",
                     move_done, bumped, map_rd_en, key_ready, player_x, player_y, exp_x, exp_y);
         end
      end else begin
         lat = 3;
         checks++;
         if ({map_rd_en, map_rd_x, map_rd_y, move_done, bumped, key_ready} !== {1'b1, 4'(tx), 4'(ty), 3'b000}) begin
            errors++;
            $display("FAIL step_read got rd=%b (%0d,%0d) done=%b bump=%b rdy=%b want 1 (%0d,%0d) 0 0 0",
                     map_rd_en, map_rd_x, map_rd_y, move_done, bumped, key_ready, tx, ty);
         end
         @(negedge clk);
         checks++;
         if ({map_rd_en, move_done, bumped, key_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL step_wait got rd=%b done=%b bump=%b rdy=%b want 0000", map_rd_en, move_done, bumped, key_ready);
         end
         @(negedge clk);
         if (!wall) begin exp_x = tx; exp_y = ty; end
         checks++;
         if ({move_done, bumped, player_x, player_y} !== {1'b1, wall, 4'(exp_x), 4'(exp_y)}) begin
            errors++;
            $display("FAIL step_commit got done=%b bump=%b pos=(%0d,%0d) want 1 %b (%0d,%0d)",
                     move_done, bumped, player_x, player_y, wall, exp_x, exp_y);
         end
      end
      // Cooldown window: no ready, no read, no repeated pulse.
      for (int k = 0; k < CD; k++) begin
         checks++;
         if (key_ready !== 1'b0 || map_rd_en !== 1'b0 || (k > 0 && move_done !== 1'b0)) begin
            errors++;
            $display("FAIL step_cool k=%0d got rdy=%b rd=%b done=%b want 0 0 0", k, key_ready, map_rd_en, move_done);
         end
         @(negedge clk);
      end
      checks++;
      if ({key_ready, move_done, player_x, player_y} !== {2'b10, 4'(exp_x), 4'(exp_y)}) begin
         errors++;
         $display("FAIL step_ready_post lat=%0d got rdy=%b done=%b pos=(%0d,%0d) want 1 0 (%0d,%0d)",
                  lat, key_ready, move_done, player_x, player_y, exp_x, exp_y);
      end
   endtask

   task automatic load_pos(input int x, input int y);
      pos_load = 1'b1; pos_load_x = 4'(x); pos_load_y = 4'(y);
      @(negedge clk);
      pos_load = 1'b0;
      exp_x = x; exp_y = y;
      checks++;
      if ({player_x, player_y, key_ready, move_done} !== {4'(x), 4'(y), 2'b10}) begin
         errors++;
         $display("FAIL pos_load got pos=(%0d,%0d) rdy=%b done=%b want (%0d,%0d) 1 0",
                  player_x, player_y, key_ready, move_done, x, y);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({player_x, player_y, key_ready, map_rd_en, move_done, bumped, map_rd_x, map_rd_y} !==
          {4'(IX), 4'(IY), 4'b1000, 8'h00}) begin
         errors++;
         $display("FAIL reset got pos=(%0d,%0d) rdy=%b rd=%b done=%b bump=%b rdxy=(%0d,%0d)",
                  player_x, player_y, key_ready, map_rd_en, move_done, bumped, map_rd_x, map_rd_y);
      end
      rst = 1'b0;
      @(negedge clk);
      exp_x = IX; exp_y = IY;
   endtask

   task automatic test_floor_and_wall();
      map_mem[3][4] = 16'h0000;
      map_mem[3][5] = RS_wall_1;
      do_step(2'd3);   // (3,3) -> (4,3)
      do_step(2'd3);   // blocked at (5,3)
      checks++;
      if ({player_x, player_y} !== {4'd4, 4'd3}) begin
         errors++;
         $display("FAIL wall_stay got (%0d,%0d) want (4,3)", player_x, player_y);
      end
   endtask

   task automatic test_edges();
      load_pos(0, 5);   do_step(2'd2);
      load_pos(15, 7);  do_step(2'd3);
      load_pos(6, 15);  do_step(2'd1);
      load_pos(9, 0);   do_step(2'd0);
   endtask

   task automatic test_key_held();
      int pulses;
      load_pos(4, 3);
      map_mem[3][3] = 16'h0013;
      pulses = 0;
      key_valid = 1'b1; key_dir = 2'd2;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (move_done === 1'b1) pulses++;
         checks++;
         if (key_ready !== (k == 7)) begin
            errors++;
            $display("FAIL held_ready k=%0d got %b want %b", k, key_ready, (k == 7));
         end
      end
      key_valid = 1'b0;
      exp_x = 3; exp_y = 3;
      checks++;
      if (pulses != 1 || {player_x, player_y} !== {4'd3, 4'd3}) begin
         errors++;
         $display("FAIL held_once got pulses=%0d pos=(%0d,%0d) want 1 (3,3)", pulses, player_x, player_y);
      end
      @(negedge clk);
   endtask

   task automatic test_load_abort();
      load_pos(7, 7);
      map_mem[7][8] = 16'h0000;
      key_valid = 1'b1; key_dir = 2'd3;
      @(negedge clk);               // READ cycle
      key_valid = 1'b0;
      pos_load = 1'b1; pos_load_x = 4'd9; pos_load_y = 4'd9;
      @(negedge clk);
      pos_load = 1'b0;
      exp_x = 9; exp_y = 9;
      checks++;
      if ({player_x, player_y, move_done, bumped, map_rd_en, key_ready} !== {8'h99, 4'b0001}) begin
         errors++;
         $display("FAIL abort_load got pos=(%0d,%0d) done=%b bump=%b rd=%b rdy=%b want (9,9) 0 0 0 1",
                  player_x, player_y, move_done, bumped, map_rd_en, key_ready);
      end
      @(negedge clk);
      checks++;
      if ({player_x, player_y, move_done, bumped, key_ready} !== {8'h99, 3'b001}) begin
         errors++;
         $display("FAIL abort_nopulse got pos=(%0d,%0d) done=%b bump=%b rdy=%b", player_x, player_y, move_done, bumped, key_ready);
      end
      // Load and key in the same IDLE cycle: the key is dropped.
      pos_load = 1'b1; pos_load_x = 4'd1; pos_load_y = 4'd1;
      key_valid = 1'b1; key_dir = 2'd3;
      @(negedge clk);
      pos_load = 1'b0; key_valid = 1'b0;
      exp_x = 1; exp_y = 1;
      checks++;
      if ({player_x, player_y, map_rd_en, move_done, key_ready} !== {8'h11, 3'b001}) begin
         errors++;
         $display("FAIL load_wins got pos=(%0d,%0d) rd=%b done=%b rdy=%b", player_x, player_y, map_rd_en, move_done, key_ready);
      end
      @(negedge clk);
      checks++;
      if ({map_rd_en, move_done, bumped, key_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL load_wins_late got rd=%b done=%b bump=%b rdy=%b", map_rd_en, move_done, bumped, key_ready);
      end
   endtask

   task automatic test_rst_mid();
      load_pos(7, 7);
      map_mem[7][8] = 16'h0000;
      key_valid = 1'b1; key_dir = 2'd3;
      @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);               // CHECK cycle
      rst = 1'b1; pos_load = 1'b1; pos_load_x = 4'd5; pos_load_y = 4'd5;
      @(negedge clk);
      rst = 1'b0; pos_load = 1'b0;
      exp_x = IX; exp_y = IY;
      checks++;
      if ({player_x, player_y, map_rd_en, move_done, bumped, key_ready} !== {4'(IX), 4'(IY), 4'b0001}) begin
         errors++;
         $display("FAIL rst_mid got pos=(%0d,%0d) rd=%b done=%b bump=%b rdy=%b",
                  player_x, player_y, map_rd_en, move_done, bumped, key_ready);
      end
      @(negedge clk);
      checks++;
      if ({move_done, bumped, player_x, player_y} !== {2'b00, 4'(IX), 4'(IY)}) begin
         errors++;
         $display("FAIL rst_mid_late got done=%b bump=%b pos=(%0d,%0d)", move_done, bumped, player_x, player_y);
      end
   endtask

   task automatic test_random_walk();
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            map_mem[y][x] = ($urandom_range(0, 9) < 3) ? 16'(RS_wall_0 + 16'($urandom_range(0, 2))) : rand_floor();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) load_pos($urandom_range(0, 15), $urandom_range(0, 15));
         do_step(2'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            map_mem[y][x] = 16'h0000;
      test_reset();
      test_floor_and_wall();
      test_edges();
      test_key_held();
      test_load_abort();
      test_rst_mid();
      test_random_walk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
